// File: rtl/fb_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// fb_mem_arb_pkg
// Shared definitions for the frame-buffer memory arbiter:
//   - request op encodings (OP_RD / OP_WR)
//   - arbiter FSM state encoding
//   - data / byte-enable widths and the out-of-range read pattern
//   - wrap_add(): modulo add used for round-robin index arithmetic
// -----------------------------------------------------------------------------
package fb_mem_arb_pkg;

    localparam int          DATA_W      = 32;
    localparam int          WBEN_W      = 4;
    localparam logic        OP_RD       = 1'b0;
    localparam logic        OP_WR       = 1'b1;
    localparam logic [31:0] RD_ERR_DATA = 32'hDEADBEEF;

    // Two-bit encoding so that the unused codes exist and recover to IDLE
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01
    } state_t;

    // (base + off) mod n, valid for base < n and off <= n
    function automatic int wrap_add(input int base, input int off, input int n);
        return ((base + off) >= n) ? (base + off - n) : (base + off);
    endfunction

endpackage

// File: rtl/fb_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// fb_mem_arbiter_if
// Bundles the engine request bus, the broadcast read-return bus and the
// frame-buffer RAM port of fb_mem_arbiter.
//   master : engine / RAM environment side (drives requests and mem_rdata)
//   slave  : arbiter side (drives grants, read returns and the RAM command)
// Parameters: NUM_REQ (requesters), ADDR_W (word address width).
// -----------------------------------------------------------------------------
interface fb_mem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 16
);
    logic [fb_mem_arb_pkg::DATA_W*NUM_REQ-1:0] req_data;
    logic [ADDR_W*NUM_REQ-1:0]                 req_addr;
    logic [fb_mem_arb_pkg::WBEN_W*NUM_REQ-1:0] req_wben;
    logic [NUM_REQ-1:0]                        req_op;
    logic [NUM_REQ-1:0]                        req_rts;
    logic [NUM_REQ-1:0]                        req_rtr;
    logic [fb_mem_arb_pkg::DATA_W-1:0]         bcast_data;
    logic [NUM_REQ-1:0]                        bcast_xfc;
    logic                                      mem_en;
    logic                                      mem_we;
    logic [fb_mem_arb_pkg::WBEN_W-1:0]         mem_wben;
    logic [ADDR_W-1:0]                         mem_addr;
    logic [fb_mem_arb_pkg::DATA_W-1:0]         mem_wdata;
    logic [fb_mem_arb_pkg::DATA_W-1:0]         mem_rdata;
    logic                                      range_err;

    modport master (
        output req_data, req_addr, req_wben, req_op, req_rts, mem_rdata,
        input  req_rtr, bcast_data, bcast_xfc, mem_en, mem_we, mem_wben,
               mem_addr, mem_wdata, range_err
    );

    modport slave (
        input  req_data, req_addr, req_wben, req_op, req_rts, mem_rdata,
        output req_rtr, bcast_data, bcast_xfc, mem_en, mem_we, mem_wben,
               mem_addr, mem_wdata, range_err
    );

endinterface

// File: rtl/fb_mem_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Scans req starting at ptr, wrapping modulo
// NUM_REQ, and reports the first requester found.
//   req : request vector          ptr : scan start index
//   en  : grant enable            gnt : one-hot grant (0 when en is low)
//   idx : binary index of the first requester found
// -----------------------------------------------------------------------------
module rr_arbiter
    import fb_mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic found_s;
    int   cand_s;

    // First-set scan from ptr upward with wrap-around
    always_comb begin
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = wrap_add(int'(ptr), k, NUM_REQ);
            if (!found_s && req[cand_s]) begin
                gnt[cand_s] = en;
                idx         = IDX_W'(cand_s);
                found_s     = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// fb_mem_arbiter
// Responder for the drawing-engine memory request bus. Grants one request per
// cycle round-robin, drives a synchronous frame-buffer RAM port and returns
// read data on a shared broadcast bus with a per-requester xfc strobe.
// Only one read is outstanding; grants are withheld while it is in flight.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fb_mem_arbiter_if.slave (requests, read return, RAM port,
//              range_err)
// Optional build macro FB_MEM_ARB_RANGE_CHK_EN: addresses >= FB_DEPTH are
// still granted but never reach the RAM; reads return RD_ERR_DATA and the
// sticky range_err flag is set. Without it range_err stays 0.
// -----------------------------------------------------------------------------
module fb_mem_arbiter
    import fb_mem_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 16,
    parameter int MEM_LAT  = 1,
    parameter int FB_DEPTH = 19200
) (
    input  logic            clk,
    input  logic            rst,
    fb_mem_arbiter_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 3;
`ifdef FB_MEM_ARB_RANGE_CHK_EN
    localparam logic RANGE_CHK = 1'b1;
`else
    localparam logic RANGE_CHK = 1'b0;
`endif

    state_t              state_r;
    logic [IDX_W-1:0]    ptr_r;
    logic [IDX_W-1:0]    rd_win_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                rd_err_r;
    logic [NUM_REQ-1:0]  gnt_s;
    logic [IDX_W-1:0]    win_idx_s;
    logic                arb_en_s;
    logic                xfer_s;
    logic [DATA_W-1:0]   win_data_s;
    logic [ADDR_W-1:0]   win_addr_s;
    logic [WBEN_W-1:0]   win_wben_s;
    logic                win_op_s;
    logic                oor_s;
    logic                mem_en_r;
    logic                mem_we_r;
    logic [WBEN_W-1:0]   mem_wben_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic [DATA_W-1:0]   bcast_data_r;
    logic [NUM_REQ-1:0]  bcast_xfc_r;
    logic                range_err_r;

    // Grants only in IDLE; held off during reset so every output reads 0
    assign arb_en_s = (state_r == IDLE) && !rst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req (bus.req_rts),
        .ptr (ptr_r),
        .en  (arb_en_s),
        .gnt (gnt_s),
        .idx (win_idx_s)
    );

    assign xfer_s = |gnt_s;

    // Select the winning requester's fields and classify its address
    always_comb begin
        win_data_s = bus.req_data[int'(win_idx_s)*DATA_W +: DATA_W];
        win_addr_s = bus.req_addr[int'(win_idx_s)*ADDR_W +: ADDR_W];
        win_wben_s = bus.req_wben[int'(win_idx_s)*WBEN_W +: WBEN_W];
        win_op_s   = bus.req_op[win_idx_s];
        oor_s      = RANGE_CHK && (32'(win_addr_s) >= 32'(FB_DEPTH));
    end

    // Read-return FSM, round-robin pointer and sticky range flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            ptr_r        <= '0;
            rd_win_r     <= '0;
            cnt_r        <= '0;
            rd_err_r     <= 1'b0;
            bcast_data_r <= '0;
            bcast_xfc_r  <= '0;
            range_err_r  <= 1'b0;
        end else begin
            bcast_xfc_r <= '0;
            range_err_r <= range_err_r | (xfer_s & oor_s);
            case (state_r)
                IDLE: begin
                    if (xfer_s) begin
                        ptr_r <= IDX_W'(wrap_add(int'(win_idx_s), 1, NUM_REQ));
                        if (win_op_s == OP_RD) begin
                            state_r  <= RD_WAIT;
                            rd_win_r <= win_idx_s;
                            cnt_r    <= CNT_W'(MEM_LAT);
                            rd_err_r <= oor_s;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_WAIT: begin
                    // Data is captured on the 1->0 step, so xfc is visible
                    // while cnt_r==0 and grants resume the cycle after it
                    if (cnt_r == '0) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= RD_WAIT;
                        cnt_r   <= cnt_r - CNT_W'(1);
                        if (cnt_r == CNT_W'(1)) begin
                            bcast_data_r          <= rd_err_r ? RD_ERR_DATA : bus.mem_rdata;
                            bcast_xfc_r[rd_win_r] <= 1'b1;
                        end else begin
                            bcast_data_r <= bcast_data_r;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Registered RAM command: one access the cycle after each transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_wben_r  <= '0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            mem_en_r <= xfer_s & ~oor_s;
            mem_we_r <= xfer_s & ~oor_s & (win_op_s == OP_WR);
            if (xfer_s) begin
                mem_wben_r  <= win_wben_s;
                mem_addr_r  <= win_addr_s;
                mem_wdata_r <= win_data_s;
            end else begin
                mem_wben_r  <= mem_wben_r;
                mem_addr_r  <= mem_addr_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    assign bus.req_rtr    = gnt_s;
    assign bus.bcast_data = bcast_data_r;
    assign bus.bcast_xfc  = bcast_xfc_r;
    assign bus.mem_en     = mem_en_r;
    assign bus.mem_we     = mem_we_r;
    assign bus.mem_wben   = mem_wben_r;
    assign bus.mem_addr   = mem_addr_r;
    assign bus.mem_wdata  = mem_wdata_r;
    assign bus.range_err  = range_err_r;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_mem_arbiter
// Scoreboard bench for fb_mem_arbiter (NUM_REQ=2, ADDR_W=16). Directed
// stimulus pushes hand-computed grants, RAM commands and read returns (with
// the cycle they must appear in) into queues; a negedge monitor pops and
// compares whenever the DUT shows req_rtr, mem_en or bcast_xfc activity.
// Honours FB_MEM_ARB_RANGE_CHK_EN for the out-of-range scenario.
// -----------------------------------------------------------------------------
module tb_fb_mem_arbiter;
    import fb_mem_arb_pkg::*;

    localparam int MEM_LAT = 1;

    typedef struct { int cyc; logic [1:0] gnt; } gnt_e_t;
    typedef struct { int cyc; logic we; logic [15:0] addr; logic [31:0] data; logic [3:0] wben; } mem_e_t;
    typedef struct { int cyc; logic [1:0] xfc; logic [31:0] data; } rd_e_t;

    logic clk;
    logic rst;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    gnt_e_t gnt_q[$];
    mem_e_t mem_q[$];
    rd_e_t  rd_q[$];
    gnt_e_t ge;
    mem_e_t me;
    rd_e_t  re;

    logic [31:0] ram [0:255];

    fb_mem_arbiter_if #(.NUM_REQ(2), .ADDR_W(16)) bus ();

    fb_mem_arbiter #(
        .NUM_REQ  (2),
        .ADDR_W   (16),
        .MEM_LAT  (MEM_LAT),
        .FB_DEPTH (19200)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: presents the word at mem_addr while the access is on the port
    assign bus.mem_rdata = ram[bus.mem_addr[7:0]];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_wben[b]) ram[bus.mem_addr[7:0]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic op, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] be);
        bus.req_op[r]           = op;
        bus.req_addr[r*16 +: 16] = a;
        bus.req_data[r*32 +: 32] = d;
        bus.req_wben[r*4 +: 4]   = be;
    endtask

    task automatic push_gnt(input int c, input logic [1:0] g);
        gnt_q.push_back('{cyc: c, gnt: g});
    endtask

    task automatic push_mem(input int c, input logic we, input logic [15:0] a,
                            input logic [31:0] d, input logic [3:0] be);
        mem_q.push_back('{cyc: c, we: we, addr: a, data: d, wben: be});
    endtask

    task automatic push_rd(input int c, input logic [1:0] x, input logic [31:0] d);
        rd_q.push_back('{cyc: c, xfc: x, data: d});
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rtr"},    64'(bus.req_rtr),    64'd0);
        chk({tag, "_bdata"},  64'(bus.bcast_data), 64'd0);
        chk({tag, "_xfc"},    64'(bus.bcast_xfc),  64'd0);
        chk({tag, "_men"},    64'(bus.mem_en),     64'd0);
        chk({tag, "_mwe"},    64'(bus.mem_we),     64'd0);
        chk({tag, "_mwben"},  64'(bus.mem_wben),   64'd0);
        chk({tag, "_maddr"},  64'(bus.mem_addr),   64'd0);
        chk({tag, "_mwdata"}, 64'(bus.mem_wdata),  64'd0);
        chk({tag, "_rerr"},   64'(bus.range_err),  64'd0);
    endtask

    // Monitor: compare every visible grant, RAM access and read return
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req_rtr != 2'b00) begin
                if (gnt_q.size() == 0) begin
                    chk("gnt_unexpected", 64'(bus.req_rtr), 64'd0);
                end else begin
                    ge = gnt_q.pop_front();
                    chk("gnt_cycle", 64'(cyc), 64'(ge.cyc));
                    chk("gnt_value", 64'(bus.req_rtr), 64'(ge.gnt));
                end
            end
            if (bus.mem_en) begin
                if (mem_q.size() == 0) begin
                    chk("mem_unexpected", 64'(bus.mem_en), 64'd0);
                end else begin
                    me = mem_q.pop_front();
                    chk("mem_cycle", 64'(cyc), 64'(me.cyc));
                    chk("mem_we", 64'(bus.mem_we), 64'(me.we));
                    chk("mem_addr", 64'(bus.mem_addr), 64'(me.addr));
                    chk("mem_wdata", 64'(bus.mem_wdata), 64'(me.data));
                    chk("mem_wben", 64'(bus.mem_wben), 64'(me.wben));
                end
            end
            if (bus.bcast_xfc != 2'b00) begin
                if (rd_q.size() == 0) begin
                    chk("xfc_unexpected", 64'(bus.bcast_xfc), 64'd0);
                end else begin
                    re = rd_q.pop_front();
                    chk("xfc_cycle", 64'(cyc), 64'(re.cyc));
                    chk("xfc_value", 64'(bus.bcast_xfc), 64'(re.xfc));
                    chk("bcast_data", 64'(bus.bcast_data), 64'(re.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0000_0000;
        bus.req_rts  = 2'b00;
        bus.req_op   = 2'b00;
        bus.req_addr = 32'h0;
        bus.req_data = 64'h0;
        bus.req_wben = 8'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // Single write from req0
        set_req(0, OP_WR, 16'h0010, 32'h00F0_F0F0, 4'hF);
        bus.req_rts = 2'b01;
        push_gnt(cyc, 2'b01);
        push_mem(cyc + 1, 1'b1, 16'h0010, 32'h00F0_F0F0, 4'hF);
        tick();
        bus.req_rts = 2'b00;

        // Single read from req1 of the word just written
        set_req(1, OP_RD, 16'h0010, 32'h0, 4'h0);
        bus.req_rts = 2'b10;
        push_gnt(cyc, 2'b10);
        push_mem(cyc + 1, 1'b0, 16'h0010, 32'h0, 4'h0);
        push_rd(cyc + MEM_LAT + 1, 2'b10, 32'h00F0_F0F0);
        tick();
        bus.req_rts = 2'b00;
        repeat (MEM_LAT + 2) tick();

        // Contention: both hold continuous writes for 6 cycles
        set_req(0, OP_WR, 16'h0020, 32'hA0A0_0000, 4'hF);
        set_req(1, OP_WR, 16'h0021, 32'hB1B1_0001, 4'h3);
        bus.req_rts = 2'b11;
        for (int k = 0; k < 6; k++) begin
            if ((k % 2) == 0) begin
                push_gnt(cyc + k, 2'b01);
                push_mem(cyc + k + 1, 1'b1, 16'h0020, 32'hA0A0_0000, 4'hF);
            end else begin
                push_gnt(cyc + k, 2'b10);
                push_mem(cyc + k + 1, 1'b1, 16'h0021, 32'hB1B1_0001, 4'h3);
            end
        end
        repeat (6) tick();
        bus.req_rts = 2'b00;
        tick();

        // Read blocking: req0 read, req1 write pending behind it
        set_req(0, OP_RD, 16'h0021, 32'h0, 4'h0);
        set_req(1, OP_WR, 16'h0030, 32'h1234_5678, 4'b0101);
        bus.req_rts = 2'b11;
        push_gnt(cyc, 2'b01);
        push_mem(cyc + 1, 1'b0, 16'h0021, 32'h0, 4'h0);
        push_rd(cyc + MEM_LAT + 1, 2'b01, 32'h0000_0001);
        push_gnt(cyc + MEM_LAT + 2, 2'b10);
        push_mem(cyc + MEM_LAT + 3, 1'b1, 16'h0030, 32'h1234_5678, 4'b0101);
        tick();
        bus.req_rts = 2'b10;
        repeat (MEM_LAT + 1) begin
            @(negedge clk);
            chk("rtr_blocked", 64'(bus.req_rtr), 64'd0);
            tick();
        end
        tick();

        // Read back the partial-byte write from req1
        set_req(1, OP_RD, 16'h0030, 32'h0, 4'h0);
        bus.req_rts = 2'b10;
        push_gnt(cyc, 2'b10);
        push_mem(cyc + 1, 1'b0, 16'h0030, 32'h0, 4'h0);
        push_rd(cyc + MEM_LAT + 1, 2'b10, 32'h0034_0078);
        tick();
        bus.req_rts = 2'b00;
        repeat (MEM_LAT + 2) tick();

        // Write with no byte enables still issues the RAM command
        set_req(0, OP_WR, 16'h0040, 32'hFFFF_FFFF, 4'h0);
        bus.req_rts = 2'b01;
        push_gnt(cyc, 2'b01);
        push_mem(cyc + 1, 1'b1, 16'h0040, 32'hFFFF_FFFF, 4'h0);
        tick();
        bus.req_rts = 2'b00;

        // Reset during RD_WAIT (pointer sits at 1 before this read)
        set_req(0, OP_RD, 16'h0010, 32'h0, 4'h0);
        bus.req_rts = 2'b01;
        push_gnt(cyc, 2'b01);
        tick();
        rst = 1'b1;
        set_req(1, OP_WR, 16'h0051, 32'h0F0F_0F0F, 4'hF);
        bus.req_rts = 2'b10;
        @(negedge clk);
        check_all_zero("midread_reset");
        tick();
        @(negedge clk);
        chk("reset_no_xfc", 64'(bus.bcast_xfc), 64'd0);
        tick();
        rst = 1'b0;
        set_req(0, OP_WR, 16'h0050, 32'h5555_AAAA, 4'hF);
        bus.req_rts = 2'b11;
        push_gnt(cyc, 2'b01);
        push_mem(cyc + 1, 1'b1, 16'h0050, 32'h5555_AAAA, 4'hF);
        push_gnt(cyc + 1, 2'b10);
        push_mem(cyc + 2, 1'b1, 16'h0051, 32'h0F0F_0F0F, 4'hF);
        repeat (2) tick();
        bus.req_rts = 2'b00;
        repeat (MEM_LAT + 2) tick();

        // Boundary address FB_DEPTH (19200) write, then read of 19201
        set_req(0, OP_WR, 16'd19200, 32'hCAFE_0000, 4'hF);
        bus.req_rts = 2'b01;
        push_gnt(cyc, 2'b01);
`ifndef FB_MEM_ARB_RANGE_CHK_EN
        push_mem(cyc + 1, 1'b1, 16'd19200, 32'hCAFE_0000, 4'hF);
`endif
        tick();
        bus.req_rts = 2'b00;
        @(negedge clk);
`ifdef FB_MEM_ARB_RANGE_CHK_EN
        chk("oor_write_men", 64'(bus.mem_en), 64'd0);
        chk("oor_write_rerr", 64'(bus.range_err), 64'd1);
`else
        chk("edge_write_men", 64'(bus.mem_en), 64'd1);
        chk("edge_write_rerr", 64'(bus.range_err), 64'd0);
`endif
        tick();
        set_req(1, OP_RD, 16'd19201, 32'h0, 4'h0);
        bus.req_rts = 2'b10;
        push_gnt(cyc, 2'b10);
`ifdef FB_MEM_ARB_RANGE_CHK_EN
        push_rd(cyc + MEM_LAT + 1, 2'b10, 32'hDEAD_BEEF);
`else
        push_mem(cyc + 1, 1'b0, 16'd19201, 32'h0, 4'h0);
        push_rd(cyc + MEM_LAT + 1, 2'b10, 32'h0000_0000);
`endif
        tick();
        bus.req_rts = 2'b00;
        repeat (MEM_LAT + 3) tick();
        @(negedge clk);
`ifdef FB_MEM_ARB_RANGE_CHK_EN
        chk("rerr_sticky", 64'(bus.range_err), 64'd1);
`else
        chk("rerr_tied", 64'(bus.range_err), 64'd0);
`endif

        chk("gnt_q_left", 64'(gnt_q.size()), 64'd0);
        chk("mem_q_left", 64'(mem_q.size()), 64'd0);
        chk("rd_q_left", 64'(rd_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
- Responder end of the engine-to-arbiter request interface used by the drawing engines (fill rect, and future line/blit engines).
- Accepts read/write requests (data, addr, wben, op, rts/rtr) from NUM_REQ engines and grants one per cycle, round-robin.
- Drives a synchronous frame-buffer RAM port.
- Returns read data on a shared broadcast bus, with a per-requester transfer-complete (xfc) strobe.

Parameters:
- NUM_REQ, 2, number of requesting engines (2..8).
- ADDR_W, 16, word address width.
- MEM_LAT, 1, RAM read latency in cycles (1..4).
- FB_DEPTH, 19200, valid word count; used only with range check.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_data  in  32*NUM_REQ  write data, requester i at [32i+31:32i].
- req_addr  in  ADDR_W*NUM_REQ  word address per requester.
- req_wben  in  4*NUM_REQ  byte write enables per requester.
- req_op  in  NUM_REQ  0=read, 1=write.
- req_rts  in  NUM_REQ  requester has a valid request.
- req_rtr  out  NUM_REQ  arbiter accepts requester i this cycle; at most one bit set.
- bcast_data  out  32  read return data, shared by all requesters.
- bcast_xfc  out  NUM_REQ  one-cycle strobe to the requester whose read data is on bcast_data.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_wben  out  4  RAM byte enables.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid MEM_LAT cycles after a mem_en read.
- range_err  out  1  sticky out-of-range flag; 0 when feature is compiled out.

Behaviour:
- Reset values:
  - all outputs 0, state IDLE, rr pointer 0.
  - bcast_data 0, bcast_xfc 0, range_err 0.
- Transfer rule: a transfer occurs when req_rts[i] & req_rtr[i].
- req_rtr is combinational:
  - set only in state IDLE;
  - goes to the first requester with rts asserted, scanning from the rr pointer upward and wrapping modulo NUM_REQ.
- Pointer update: after each transfer the rr pointer becomes winner+1 (mod NUM_REQ). No transfer leaves the pointer unchanged.
- Memory drive: registered. The cycle after a transfer:
  - mem_en=1, mem_addr/mem_wben/mem_wdata taken from the winner;
  - mem_we=req_op.
  - With no transfer, mem_en=0 and mem_we=0; address and data hold their last values.
- Writes:
  - no response is returned; state stays IDLE;
  - back-to-back writes are accepted one per cycle;
  - wben=0 still issues mem_en with mem_we=1 (RAM ignores it).
- Reads:
  - state goes IDLE->RD_WAIT; the winner index is latched and a counter is loaded with MEM_LAT.
  - RD_WAIT decrements each cycle. On reaching 0, bcast_data<=mem_rdata and bcast_xfc[winner]<=1 for exactly one cycle, then state returns to IDLE.
  - Read-to-xfc latency is MEM_LAT+1 cycles after the transfer cycle.
  - req_rtr stays 0 throughout RD_WAIT, so only one read is outstanding at a time.
- bcast_data holds its last value between reads. bcast_xfc is 0 except on the return cycle.
- Simultaneous requests: a pending write from another requester during a read waits until IDLE; round-robin order is preserved.
- Reset mid-read: the read is abandoned, no xfc is issued, and the pointer returns to 0.
- Illegal state encodings recover to IDLE.

Optional Feature:
- Macro: FB_MEM_ARB_RANGE_CHK_EN.
- With the macro defined, addresses >= FB_DEPTH are still accepted and arbitrated normally, but:
  - writes issue with mem_en=0 and mem_we=0;
  - reads complete with normal timing, returning 32'hDEADBEEF with xfc;
  - range_err is set and stays set until reset.
- Without the macro, addresses pass unchecked and range_err is tied to 0.

Decomposition:
- Package fb_mem_arb_pkg holds:
  - op encodings OP_RD=0, OP_WR=1;
  - state encodings IDLE and RD_WAIT;
  - constant RD_ERR_DATA=32'hDEADBEEF;
  - data width 32 and wben width 4.
- Sub-module rr_arbiter (parameter NUM_REQ):
  - inputs: req vector, pointer, enable;
  - outputs: one-hot grant and binary winner index.
- Top level holds the FSM, memory registers and return path.

Test Plan:
- Single write: req0 write addr 16'h0010, data 32'h00F0F0F0, wben 4'hF. Expect req_rtr[0]=1 the same cycle; next cycle mem_en=1, mem_we=1, addr 16'h0010; no xfc.
- Single read, MEM_LAT=1: after the write above, req1 reads 16'h0010. Expect bcast_xfc=2'b10 two cycles after the transfer, bcast_data=32'h00F0F0F0, and bcast_xfc[0] never set.
- Contention: both requesters hold rts with continuous writes for 6 cycles. Expect grants alternating 0,1,0,1,0,1 and each mem write issued one cycle after its grant.
- Read blocking: req0 read with req1 write pending. Expect req_rtr=0 for MEM_LAT+1 cycles; the req1 write is granted in the cycle after xfc.
- Reset mid-read: assert rst during RD_WAIT. Expect all outputs 0, no xfc after release, and the first post-reset grant goes to req0 when both request.
- FB_MEM_ARB_RANGE_CHK_EN defined:
  - write addr 19200: expect mem_en=0 and range_err=1;
  - subsequent read of addr 19201: expect bcast_data=32'hDEADBEEF with xfc.
